// File: rtl/binop_pkg.sv
// Shared definitions for the binary-op issue stage and the downstream op unit:
// opcode enum, skid-buffer state encoding and opcode classification helpers.
package binop_pkg;

  localparam int BINOP_OP_W = 4;

  typedef enum logic [BINOP_OP_W-1:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_ADD = 4'd3,
    OP_SUB = 4'd4,
    OP_LT  = 4'd5,
    OP_LE  = 4'd6,
    OP_EQ  = 4'd7,
    OP_NE  = 4'd8,
    OP_GT  = 4'd9,
    OP_GE  = 4'd10,
    OP_SHL = 4'd11,
    OP_SHR = 4'd12
  } binop_e;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_HALF,
    SKID_FULL
  } skid_state_e;

  function automatic logic is_shift(input logic [BINOP_OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Encodings above the last shift opcode are reserved.
  function automatic logic is_legal(input logic [BINOP_OP_W-1:0] op);
    return op <= OP_SHR;
  endfunction

endpackage

// File: rtl/binop_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register feeds the output,
// skid register catches the one request that arrives while the output stalls.
module binop_skid_buf
  import binop_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  skid_state_e   state, state_n;
  logic [PW-1:0] main_q, skid_q;
  logic          push, pop;
  logic          load_main, load_skid, main_from_skid;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign out_data = main_q;

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_n   = SKID_HALF;
        end
      end
      SKID_HALF: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_n   = SKID_FULL;
        end else if (pop) begin
          state_n = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          main_from_skid = 1'b1;
          state_n        = SKID_HALF;
        end
      end
      default: state_n = SKID_EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so neither output
  // depends combinationally on the other side of the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SKID_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n != SKID_FULL);
      out_valid <= (state_n != SKID_EMPTY);
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/binop_issue_stage.sv
// Registered issue stage ahead of the combinational binary-op unit.
// Optional BINOP_ISSUE_STATS_EN adds issue_count / illegal_count outputs.
module binop_issue_stage
  import binop_pkg::*;
#(
  parameter  int W  = 4,
  parameter  int RW = 5,
  localparam int SW = $clog2(RW) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BINOP_OP_W-1:0] in_op,
  input  logic                  in_signed,
  input  logic [W-1:0]          in_a,
  input  logic [W-1:0]          in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BINOP_OP_W-1:0] out_op,
  output logic                  out_signed,
  output logic [RW-1:0]         out_a,
  output logic [RW-1:0]         out_b,
  output logic [SW-1:0]         out_shamt,
  output logic                  err_illegal
`ifdef BINOP_ISSUE_STATS_EN
  ,
  output logic [31:0]           issue_count,
  output logic [15:0]           illegal_count
`endif
);

  localparam int PW = BINOP_OP_W + 1 + 2 * RW + SW;

  logic          legal, shift, illegal_accept;
  logic [RW-1:0] a_ext, b_ext, b_out;
  logic [SW-1:0] shamt, shamt_out;
  int unsigned   b_u;
  logic [PW-1:0] in_pl, out_pl;

  assign legal          = is_legal(in_op);
  assign shift          = is_shift(in_op);
  assign illegal_accept = in_valid && in_ready && !legal;

  // Replicating the fill bit ahead of the operand and truncating gives both
  // sign and zero extension, and stays well-formed when RW equals W.
  always_comb begin
    a_ext = RW'({{RW{in_signed && in_a[W-1]}}, in_a});
    b_ext = RW'({{RW{in_signed && in_b[W-1]}}, in_b});
    b_u   = 32'(in_b);
    shamt = (b_u > $unsigned(RW)) ? SW'(RW) : SW'(b_u);
    b_out     = shift ? '0 : b_ext;
    shamt_out = shift ? shamt : '0;
    in_pl     = {in_op, in_signed, a_ext, b_out, shamt_out};
  end

  binop_skid_buf #(
    .PW(PW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid && legal),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl)
  );

  assign {out_op, out_signed, out_a, out_b, out_shamt} = out_pl;

  // Illegal requests complete the handshake but never enter the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= illegal_accept;
    end
  end

`ifdef BINOP_ISSUE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_count   <= '0;
      illegal_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        issue_count <= issue_count + 32'd1;
      end
      if (illegal_accept) begin
        illegal_count <= illegal_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_binop_issue_stage.sv
// Self-checking bench for binop_issue_stage: a queue-based reference model is
// compared every cycle, plus hand-computed literal checks for key scenarios.
module tb_binop_issue_stage;
  import binop_pkg::*;

  localparam int W  = 4;
  localparam int RW = 5;
  localparam int SW = $clog2(RW) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic          in_signed;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_op;
  logic          out_signed;
  logic [RW-1:0] out_a;
  logic [RW-1:0] out_b;
  logic [SW-1:0] out_shamt;
  logic          err_illegal;
`ifdef BINOP_ISSUE_STATS_EN
  logic [31:0]   issue_count;
  logic [15:0]   illegal_count;
`endif

  binop_issue_stage #(
    .W (W),
    .RW(RW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_signed (out_signed),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_shamt  (out_shamt),
    .err_illegal(err_illegal)
`ifdef BINOP_ISSUE_STATS_EN
    ,
    .issue_count  (issue_count),
    .illegal_count(illegal_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a FIFO of at most two expected outputs.
  typedef struct {
    int op;
    int sgn;
    int a;
    int b;
    int sh;
  } exp_t;

  exp_t        q[$];
  bit          model_ready = 1'b0;
  bit          exp_err = 1'b0;
  bit          m_acc, m_pop;
  int          pops = 0;
  int unsigned issue_m = 0;
  int unsigned illegal_m = 0;

  function automatic int extend(int v, int sgn);
    int r;
    r = (sgn != 0 && v >= (1 << (W - 1))) ? v - (1 << W) : v;
    return r & ((1 << RW) - 1);
  endfunction

  function automatic exp_t expect_of(int op, int sgn, int a, int b);
    exp_t e;
    e.op  = op;
    e.sgn = sgn;
    e.a   = extend(a, sgn);
    if (op == 11 || op == 12) begin
      e.b  = 0;
      e.sh = (b > RW) ? RW : b;
    end else begin
      e.b  = extend(b, sgn);
      e.sh = 0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_err   = 1'b0;
      issue_m   = 0;
      illegal_m = 0;
    end else begin
      m_acc   = in_valid && (q.size() < 2);
      m_pop   = (q.size() > 0) && out_ready;
      exp_err = m_acc && (int'(in_op) > 12);
      if (m_pop) begin
        void'(q.pop_front());
        pops++;
        issue_m++;
      end
      if (m_acc && int'(in_op) <= 12) begin
        q.push_back(expect_of(int'(in_op), int'(in_signed), int'(in_a), int'(in_b)));
      end
      if (exp_err) illegal_m++;
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("cmp_out_valid", out_valid, q.size() > 0);
      checkOutput("cmp_in_ready", in_ready, q.size() < 2);
      checkOutput("cmp_err_illegal", err_illegal, exp_err);
      if (q.size() > 0) begin
        checkOutput("cmp_out_op", out_op, q[0].op);
        checkOutput("cmp_out_signed", out_signed, q[0].sgn);
        checkOutput("cmp_out_a", out_a, q[0].a);
        checkOutput("cmp_out_b", out_b, q[0].b);
        checkOutput("cmp_out_shamt", out_shamt, q[0].sh);
      end
`ifdef BINOP_ISSUE_STATS_EN
      checkOutput("cmp_issue_count", issue_count, issue_m);
      checkOutput("cmp_illegal_count", illegal_count, 16'(illegal_m));
`endif
    end
  end

  // Holds the request until the DUT accepts it, returns 1 time unit after
  // the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid  = 1'b1;
    in_op     = op;
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got in_ready 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic driveOnly(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = 1'b1;
    in_op     = op;
    in_signed = 1'b0;
    in_a      = a;
    in_b      = b;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_err_illegal", err_illegal, 0);
    checkOutput("rst_out_a", out_a, 0);
    checkOutput("rst_out_op", out_op, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    applyStimulus(OP_ADD, 1'b1, 4'hF, 4'h7);
    checkOutput("add_valid", out_valid, 1);
    checkOutput("add_op", out_op, 3);
    checkOutput("add_a", out_a, 5'h1F);
    checkOutput("add_b", out_b, 5'h07);
    checkOutput("add_shamt", out_shamt, 0);

    applyStimulus(OP_SHL, 1'b0, 4'h9, 4'hF);
    checkOutput("shl_a", out_a, 5'h09);
    checkOutput("shl_b", out_b, 0);
    checkOutput("shl_shamt_sat", out_shamt, 5);

    applyStimulus(OP_SHL, 1'b0, 4'h9, 4'h2);
    checkOutput("shl_shamt_2", out_shamt, 2);

    applyStimulus(OP_SHR, 1'b1, 4'h8, 4'h5);
    checkOutput("shr_a_signed", out_a, 5'h18);
    checkOutput("shr_shamt_eq", out_shamt, 5);

    applyStimulus(OP_SUB, 1'b1, 4'h8, 4'h3);
    checkOutput("sub_a", out_a, 5'h18);
    checkOutput("sub_b", out_b, 5'h03);

    applyStimulus(OP_LT, 1'b0, 4'h8, 4'hC);
    checkOutput("lt_a", out_a, 5'h08);
    checkOutput("lt_b", out_b, 5'h0C);

    // Backpressure: third request stalls until the buffer drains.
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    driveOnly(OP_ADD, 4'd1, 4'd1);
    @(posedge clk);
    #1;
    driveOnly(OP_ADD, 4'd2, 4'd2);
    @(posedge clk);
    #1;
    checkOutput("bp_in_ready_full", in_ready, 0);
    checkOutput("bp_head_first", out_a, 1);
    driveOnly(OP_ADD, 4'd3, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_still_full", in_ready, 0);
    checkOutput("bp_head_held", out_a, 1);
    out_ready = 1'b1;
    applyStimulus(OP_ADD, 1'b0, 4'd3, 4'd3);
    checkOutput("bp_third_head", out_a, 3);

    // Streaming at one op per cycle.
    repeat (2) @(posedge clk);
    #1;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      driveOnly(OP_XOR, 4'(i), 4'd1);
      @(posedge clk);
      #1;
      checkOutput("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stream_count", pops - p0, 20);

    // Illegal opcode: accepted, flagged for one cycle, never issued.
    applyStimulus(4'd14, 1'b0, 4'd5, 4'd5);
    checkOutput("ill_err_pulse", err_illegal, 1);
    checkOutput("ill_no_valid", out_valid, 0);
`ifdef BINOP_ISSUE_STATS_EN
    checkOutput("ill_count", illegal_count, 1);
`endif
    @(posedge clk);
    #1;
    checkOutput("ill_err_clear", err_illegal, 0);

    // Reset while both entries are occupied.
    out_ready = 1'b0;
    driveOnly(OP_OR, 4'd6, 4'd6);
    @(posedge clk);
    #1;
    driveOnly(OP_OR, 4'd7, 4'd7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("rstfull_in_ready", in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstfull_out_valid", out_valid, 0);
    checkOutput("rstfull_in_ready_after", in_ready, 1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    p0        = pops;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstfull_no_output", out_valid, 0);
    checkOutput("rstfull_no_pops", pops - p0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
